// File: rtl/snake_pkg.sv
// snake_pkg: shared types and constants for the snake game blocks
package snake_pkg;
    typedef enum logic [1:0] {PLACED, GEN, QUERY, DONE} state_t;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam int DEF_GRID_W = 64;
    localparam int DEF_GRID_H = 48;
    localparam int DEF_X_W = 7;
    localparam int DEF_Y_W = 6;
endpackage

// File: rtl/apple_spawner_if.sv
// apple_spawner_if: occupancy query handshake between spawner and body tracker
interface apple_spawner_if import snake_pkg::*; #(
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W
);
    logic req;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic ack;
    logic hit;
    modport master(output req, x, y, input ack, hit);
    modport slave(input req, x, y, output ack, hit);
endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR that never holds zero
module lfsr16 import snake_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);
    localparam logic [15:0] INIT = (SEED == 16'd0) ? 16'd1 : SEED;
    // shift right, folding the dropped bit back in through the taps
    always_ff @(posedge clk)
        q <= reset ? INIT : (q >> 1) ^ (q[0] ? LFSR_TAPS : 16'h0000);
endmodule

// File: rtl/apple_spawner.sv
// apple_spawner: apple placement, eat detection, score and random respawn
module apple_spawner import snake_pkg::*; #(
    parameter int GRID_W = DEF_GRID_W,
    parameter int GRID_H = DEF_GRID_H,
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W,
    parameter int SCORE_W = 4,
    parameter int SCORE_MAX = 10,
    parameter int INIT_X = 15,
    parameter int INIT_Y = 33,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               head_valid,
    input  logic [X_W-1:0]     head_x,
    input  logic [Y_W-1:0]     head_y,
    apple_spawner_if.master    occ,
    output logic [X_W-1:0]     apple_x,
    output logic [Y_W-1:0]     apple_y,
    output logic               apple_valid,
    output logic [SCORE_W-1:0] score,
    output logic               eaten,
    output logic               win
);
    state_t state;
    logic [15:0] rnd;
    logic [X_W-1:0] cx, hx;
    logic [Y_W-1:0] cy, hy;
    logic [SCORE_W-1:0] nscore;
    logic reject;
    logic unused_bits;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .q(rnd));

    // candidate bits wrap around the 16-bit LFSR when the coordinates need more
    for (genvar i = 0; i < X_W; i++) begin : g_cx
        assign cx[i] = rnd[i % 16];
    end
    for (genvar i = 0; i < Y_W; i++) begin : g_cy
        assign cy[i] = rnd[(X_W + i) % 16];
    end

    assign unused_bits = ^rnd;
    assign nscore = score + SCORE_W'(1);
    assign reject = (32'(cx) >= GRID_W) || (32'(cy) >= GRID_H) || (cx == hx && cy == hy);

    // eat detection, respawn search and occupancy handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLACED;
            apple_x     <= X_W'(INIT_X);
            apple_y     <= Y_W'(INIT_Y);
            apple_valid <= 1'b1;
            score       <= '0;
            eaten       <= 1'b0;
            win         <= 1'b0;
            occ.req     <= 1'b0;
            occ.x       <= '0;
            occ.y       <= '0;
            hx          <= '0;
            hy          <= '0;
        end else begin
            eaten <= 1'b0;
            case (state)
                PLACED: if (head_valid && head_x == apple_x && head_y == apple_y) begin
                    eaten       <= 1'b1;
                    score       <= nscore;
                    apple_valid <= 1'b0;
                    hx          <= head_x;
                    hy          <= head_y;
                    win         <= nscore == SCORE_W'(SCORE_MAX);
                    state       <= (nscore == SCORE_W'(SCORE_MAX)) ? DONE : GEN;
                end
                GEN: if (!reject) begin
                    occ.x   <= cx;
                    occ.y   <= cy;
                    occ.req <= 1'b1;
                    state   <= QUERY;
                end
                QUERY: if (occ.ack) begin
                    occ.req <= 1'b0;
                    if (!occ.hit) begin
                        apple_x     <= occ.x;
                        apple_y     <= occ.y;
                        apple_valid <= 1'b1;
                    end
                    state <= occ.hit ? GEN : PLACED;
                end
                DONE: begin
                    apple_valid <= 1'b0;
                    win         <= 1'b1;
                end
                default: state <= PLACED;
            endcase
        end
    end
endmodule
